// File: rtl/dlock_pkg.sv
// Shared constants for the door-lock keystore: FSM state encodings,
// the rejected all-zero code and the factory default code.
package dlock_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_UNLOCKED = 2'd1;
  localparam logic [1:0] ST_LOCKOUT  = 2'd2;

  localparam logic [15:0] REJECT_CODE  = 16'h0000;
  localparam logic [15:0] DEFAULT_CODE = 16'h1234;

endpackage

// File: rtl/dlock_lockout_timer.sv
// 16-bit lockout down-counter: load sets the start value, expire is high
// while enabled and the count has reached zero.
module dlock_lockout_timer (
  input  logic        clk,
  input  logic        rstn,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        en,
  output logic        expire
);

  logic [15:0] count;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= 16'd0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != 16'd0)) begin
      count <= count - 16'd1;
    end
  end

  assign expire = en && (count == 16'd0);

endmodule

// File: rtl/dlock_keystore.sv
// Keystore for the door lock: holds the secret code, compares entered codes,
// counts failures, enforces a timed lockout and handles code reprogramming.
module dlock_keystore #(
  parameter logic [15:0] DEFAULT_CODE   = dlock_pkg::DEFAULT_CODE,
  parameter int          MAX_FAILS      = 3,
  parameter int          LOCKOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [15:0] Full_Input,
  input  logic        code_ready,
  input  logic        lock,
  input  logic        Error,
  input  logic        relock,
  input  logic        prog_req,
  output logic        lockcomp,
  output logic        lockout,
  output logic [1:0]  fail_cnt,
  output logic        prog_ack,
  output logic        prog_nack,
  output logic [1:0]  dbg_state
);
  import dlock_pkg::*;

  localparam logic [2:0]  MAX_FAILS_3 = 3'(MAX_FAILS);
  localparam logic [1:0]  MAX_FAILS_2 = 2'(MAX_FAILS);
  localparam logic [15:0] TIMER_LOAD  = 16'(LOCKOUT_CYCLES - 1);

  logic [1:0]  state;
  logic [15:0] stored_code;
  logic        err_q;
  logic        err_rise;
  logic        trip;
  logic        code_match;
  logic        timer_load;
  logic        timer_en;
  logic        timer_expire;

  assign err_rise   = Error && !err_q;
  assign trip       = ({1'b0, fail_cnt} + 3'd1) >= MAX_FAILS_3;
  assign code_match = (Full_Input == stored_code);
  // Lock beats a coincident Error edge, so only load the timer without lock.
  assign timer_load = (state == ST_IDLE) && !lock && err_rise && trip;
  assign timer_en   = (state == ST_LOCKOUT);
  assign dbg_state  = state;

  dlock_lockout_timer u_timer (
    .clk      (clk),
    .rstn     (rstn),
    .load     (timer_load),
    .load_val (TIMER_LOAD),
    .en       (timer_en),
    .expire   (timer_expire)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      stored_code <= DEFAULT_CODE;
      lockcomp    <= 1'b0;
      lockout     <= 1'b0;
      fail_cnt    <= 2'd0;
      prog_ack    <= 1'b0;
      prog_nack   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q     <= Error;
      prog_ack  <= 1'b0;
      prog_nack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (relock) begin
            lockcomp <= 1'b0;
          end else if (code_ready) begin
            lockcomp <= code_match;
          end
          if (lock) begin
            state    <= ST_UNLOCKED;
            fail_cnt <= 2'd0;
          end else if (err_rise) begin
            if (trip) begin
              state    <= ST_LOCKOUT;
              lockout  <= 1'b1;
              lockcomp <= 1'b0;
              fail_cnt <= MAX_FAILS_2;
            end else begin
              fail_cnt <= fail_cnt + 2'd1;
            end
          end
        end
        ST_UNLOCKED: begin
          if (relock) begin
            state    <= ST_IDLE;
            lockcomp <= 1'b0;
          end else if (code_ready) begin
            if (!prog_req) begin
              lockcomp <= code_match;
            end else if (Full_Input == REJECT_CODE) begin
              prog_nack <= 1'b1;
            end else begin
              stored_code <= Full_Input;
              prog_ack    <= 1'b1;
            end
          end
        end
        ST_LOCKOUT: begin
          lockcomp <= 1'b0;
          if (timer_expire) begin
            state    <= ST_IDLE;
            lockout  <= 1'b0;
            fail_cnt <= 2'd0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
